// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide controller: registered operands feed a multicycle multiplier path.
// Define MDU_DIV_EN to add the 32-step restoring unsigned divider (DIVU/REMU).
module mdu_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy
);

    localparam int unsigned CW = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   op_a, op_b;
    logic [31:0]   mul_out;

    assign req_ready  = (state == S_IDLE) && !flush;
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_DONE);

    // op_a/op_b only change in IDLE, so this product is a multicycle path
    assign mul_out = op_a * op_b;

`ifdef MDU_DIV_EN
    logic        div_quo;
    logic [31:0] rem, dvd;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_nxt, quo_nxt;

    // Partial remainder carries an extra bit so divisors above 2^31 compare correctly
    always_comb begin
        rem_sh  = {rem, dvd[31]};
        ge      = (rem_sh >= {1'b0, op_b});
        rem_nxt = ge ? 32'(rem_sh - {1'b0, op_b}) : rem_sh[31:0];
        quo_nxt = {dvd[30:0], ge};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        case (req_op)
                            OP_MUL:  state_nxt = S_MUL;
`ifdef MDU_DIV_EN
                            OP_DIVU,
                            OP_REMU: state_nxt = (req_rs2 == '0) ? S_DONE : S_DIV;
`endif
                            default: state_nxt = S_DONE;
                        endcase
                    end
                end
                S_MUL:   if (cnt == '0) state_nxt = S_DONE;
`ifdef MDU_DIV_EN
                S_DIV:   if (cnt == '0) state_nxt = S_DONE;
`endif
                S_DONE:  if (resp_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A flush freezes the datapath, so an aborted op never reaches resp_data
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            resp_data <= '0;
`ifdef MDU_DIV_EN
            div_quo   <= 1'b0;
            rem       <= '0;
            dvd       <= '0;
`endif
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_a <= req_rs1;
                        op_b <= req_rs2;
                        case (req_op)
                            OP_MUL: cnt <= CW'(MUL_LAT - 1);
                            OP_DIVU,
                            OP_REMU: begin
`ifdef MDU_DIV_EN
                                div_quo <= (req_op == OP_DIVU);
                                if (req_rs2 == '0) begin
                                    resp_data <= (req_op == OP_DIVU) ? 32'hFFFF_FFFF : req_rs1;
                                end else begin
                                    cnt <= CW'(31);
                                    rem <= '0;
                                    dvd <= req_rs1;
                                end
`else
                                resp_data <= '0;
`endif
                            end
                            default: resp_data <= '0;
                        endcase
                    end
                end
                S_MUL: begin
                    if (cnt == '0) resp_data <= mul_out;
                    else           cnt       <= cnt - CW'(1);
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    rem <= rem_nxt;
                    dvd <= quo_nxt;
                    if (cnt == '0) resp_data <= div_quo ? quo_nxt : rem_nxt;
                    else           cnt       <= cnt - CW'(1);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for single ops plus hand sequences for stalls, flush and reset.
module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int DIV_LAT = DIV_EN ? 33 : 1;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, resp_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic        req_ready, resp_valid, busy;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Called just after a negedge; returns #1 after the accepting edge (cycle 1)
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        #1;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResp(output int lat, output int busyBad);
        lat     = 0;
        busyBad = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busyBad++;
            if (resp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake(input string name, input logic [31:0] expData);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, "_post_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({name, "_post_busy"},  32'(busy),       32'd0);
        checkOutput({name, "_post_ready"}, 32'(req_ready),  32'd1);
        checkOutput({name, "_post_data"},  resp_data,       expData);
    endtask

    task automatic runVector(input vec_t v);
        int lat, busyBad;
        applyStimulus(v.op, v.a, v.b);
        waitResp(lat, busyBad);
        checkOutput({v.name, "_lat"},  32'(lat),     32'(v.expLat));
        checkOutput({v.name, "_data"}, resp_data,    v.expData);
        checkOutput({v.name, "_busy"}, 32'(busyBad), 32'd0);
        handshake(v.name, v.expData);
    endtask

    initial begin
        int lat, busyBad, validBad;

        vecs[0]  = '{"mul_small",  2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, MUL_LAT + 1};
        vecs[1]  = '{"mul_ones",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT + 1};
        vecs[2]  = '{"mul_wrap",   2'b00, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, MUL_LAT + 1};
        vecs[3]  = '{"mul_6x7",    2'b00, 32'd6,         32'd7,         32'd42,        MUL_LAT + 1};
        vecs[4]  = '{"divu_100_7", 2'b01, 32'd100,       32'd7,         DIV_EN ? 32'd14 : 32'd0, DIV_LAT};
        vecs[5]  = '{"remu_100_7", 2'b10, 32'd100,       32'd7,         DIV_EN ? 32'd2  : 32'd0, DIV_LAT};
        vecs[6]  = '{"divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1,         DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_LAT};
        vecs[7]  = '{"divu_by0",   2'b01, 32'h0000_1234, 32'd0,         DIV_EN ? 32'hFFFF_FFFF : 32'd0, 1};
        vecs[8]  = '{"remu_by0",   2'b10, 32'h0000_1234, 32'd0,         DIV_EN ? 32'h0000_1234 : 32'd0, 1};
        vecs[9]  = '{"divu_big",   2'b01, 32'hFFFF_FFFF, 32'h8000_0001, DIV_EN ? 32'd1 : 32'd0, DIV_LAT};
        vecs[10] = '{"remu_big",   2'b10, 32'hFFFF_FFFF, 32'h8000_0001, DIV_EN ? 32'h7FFF_FFFE : 32'd0, DIV_LAT};
        vecs[11] = '{"op_rsvd",    2'b11, 32'd5,         32'd6,         32'd0,         1};

        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        req_op     = 2'b00;
        req_rs1    = '0;
        req_rs2    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_data",  resp_data,       32'd0);
        checkOutput("rst_busy",  32'(busy),       32'd0);
        checkOutput("rst_ready", 32'(req_ready),  32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) runVector(vecs[i]);

        $display("[TB] response held in DONE with consumer stalled");
        applyStimulus(2'b00, 32'd6, 32'd7);
        waitResp(lat, busyBad);
        checkOutput("stall_lat", 32'(lat), 32'(MUL_LAT + 1));
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_rs1   = 32'd9;
        req_rs2   = 32'd9;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_valid", 32'(resp_valid), 32'd1);
            checkOutput("stall_data",  resp_data,       32'd42);
            checkOutput("stall_ready", 32'(req_ready),  32'd0);
        end
        req_valid = 1'b0;
        handshake("stall", 32'd42);

        $display("[TB] request during flush in IDLE");
        req_valid = 1'b1;
        flush     = 1'b1;
        req_rs1   = 32'd3;
        req_rs2   = 32'd3;
        #1;
        checkOutput("flush_idle_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        checkOutput("flush_idle_busy", 32'(busy), 32'd0);

        $display("[TB] flush of an in-flight op");
        applyStimulus(DIV_EN ? 2'b01 : 2'b00, 32'd100, 32'd7);
        repeat (DIV_EN ? 9 : 0) @(posedge clk);
        @(negedge clk);
        checkOutput("flush_op_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_op_busy",  32'(busy),       32'd0);
        checkOutput("flush_op_valid", 32'(resp_valid), 32'd0);
        checkOutput("flush_op_ready", 32'(req_ready),  32'd1);
        validBad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || busy !== 1'b0) validBad++;
        end
        checkOutput("flush_op_quiet", 32'(validBad), 32'd0);
        runVector(vecs[3]);

        $display("[TB] flush in DONE with consumer ready");
        applyStimulus(2'b00, 32'd5, 32'd5);
        waitResp(lat, busyBad);
        checkOutput("flush_done_data", resp_data, 32'd25);
        flush      = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("flush_done_valid", 32'(resp_valid), 32'd0);
        checkOutput("flush_done_busy",  32'(busy),       32'd0);

        $display("[TB] reset during MUL");
        applyStimulus(2'b00, 32'd3, 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 32'(resp_valid), 32'd0);
        checkOutput("midrst_data",  resp_data,       32'd0);
        checkOutput("midrst_busy",  32'(busy),       32'd0);
        checkOutput("midrst_ready", 32'(req_ready),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
